uart_alu_interface: RTL and testbench

Command responder between the UART receiver and the UART transmitter. Collects three received bytes (operand A, operand B, opcode) and evaluates them in an internal ALU. Hands the 8-bit result to the transmitter with a one-cycle valid pulse, then waits for transmit completion before accepting the next command. Sits at top level beside baud_rate_generator, receiver and transmitter on the shared system clock.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/alu.sv | 38 +++
 rtl/uart_alu_interface.sv | 136 +++++++++++++
 tb/tb_uart_alu_interface.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths, opcodes and FSM state encoding for the UART ALU responder.
package uart_pkg;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations, wraps mod 2^NB_DATA, flags unknown opcodes.
module alu
  import uart_pkg::*;
(
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] result,
  output logic               op_valid
);

  logic shift_oob;

  // Shift amounts of NB_DATA or more saturate rather than relying on operator behaviour.
  assign shift_oob = (b >= NB_DATA[NB_DATA-1:0]);

  // Operation select; unsupported opcodes produce zero and clear op_valid.
  always_comb begin
    result   = '0;
    op_valid = 1'b1;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SRL: result = shift_oob ? '0 : (a >> b);
      OP_SRA: result = shift_oob ? {NB_DATA{a[NB_DATA-1]}}
                                 : NB_DATA'($signed(a) >>> b);
      default: begin
        result   = '0;
        op_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, evaluates them and
// hands the result to the transmitter, waiting for its completion.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_interface_data,
  output logic               o_interface_done,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_overrun
);

  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] data_d;
  logic               done_d, busy_d, err_d, ovr_d;
  logic               timeout_hit;
  logic [NB_DATA-1:0] alu_result;
  logic               alu_op_valid;

  alu u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_result),
    .op_valid (alu_op_valid)
  );

  // Timeout fires after TIMEOUT_CYCLES idle cycles in WAIT_B/WAIT_OP.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = o_interface_data;
    err_d   = o_op_error;
    ovr_d   = 1'b0;
    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          cnt_d   = '0;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          cnt_d   = '0;
          state_d = ST_WAIT_OP;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = ST_WAIT_A;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OP-1:0];
          cnt_d   = '0;
          state_d = ST_COMPUTE;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = ST_WAIT_A;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMPUTE: begin
        data_d  = alu_result;
        err_d   = ~alu_op_valid;
        ovr_d   = i_rx_done;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        ovr_d   = i_rx_done;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        ovr_d = i_rx_done;
        if (i_tx_done) state_d = ST_WAIT_A;
      end
      default: state_d = ST_WAIT_A;
    endcase
    done_d = (state_d == ST_SEND);
    busy_d = (state_d == ST_COMPUTE) || (state_d == ST_SEND) || (state_d == ST_WAIT_TX);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q          <= ST_WAIT_A;
      a_q              <= '0;
      b_q              <= '0;
      op_q             <= '0;
      cnt_q            <= '0;
      o_interface_data <= '0;
      o_interface_done <= 1'b0;
      o_busy           <= 1'b0;
      o_op_error       <= 1'b0;
      o_overrun        <= 1'b0;
    end else begin
      state_q          <= state_d;
      a_q              <= a_d;
      b_q              <= b_d;
      op_q             <= op_d;
      cnt_q            <= cnt_d;
      o_interface_data <= data_d;
      o_interface_done <= done_d;
      o_busy           <= busy_d;
      o_op_error       <= err_d;
      o_overrun        <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface against an arithmetic reference model.
module tb_uart_alu_interface;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_interface_data;
  logic       o_interface_done;
  logic       o_busy;
  logic       o_op_error;
  logic       o_overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_alu_interface #(.TIMEOUT_CYCLES(16)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_rx_data        (i_rx_data),
    .i_rx_done        (i_rx_done),
    .i_tx_done        (i_tx_done),
    .o_interface_data (o_interface_data),
    .o_interface_done (o_interface_done),
    .o_busy           (o_busy),
    .o_op_error       (o_op_error),
    .o_overrun        (o_overrun)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "timeout");
  end

  // Reference: plain integer arithmetic on byte values.
  function automatic void model(input int a, input int b, input int opbyte,
                                output int r, output bit err);
    int op, sa, p;
    op  = opbyte % 64;
    err = 1'b0;
    case (op)
      32: r = (a + b) % 256;
      34: r = (a - b + 256) % 256;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      2:  r = (b >= 8) ? 0 : a / (1 << b);
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) r = (sa < 0) ? 255 : 0;
        else begin
          p = 1 << b;
          r = (sa >= 0) ? sa / p : (sa - (p - 1)) / p;
          r = (r + 256) % 256;
        end
      end
      default: begin r = 0; err = 1'b1; end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] v);
    @(negedge i_clock);
    i_rx_data = v;
    i_rx_done = 1'b1;
    @(posedge i_clock);
    #1 i_rx_done = 1'b0;
  endtask

  task automatic send_tx();
    @(negedge i_clock);
    i_tx_done = 1'b1;
    @(posedge i_clock);
    #1 i_tx_done = 1'b0;
  endtask

  // Sends a triple; lat = edges after the opcode edge until done is seen (1 means
  // the transmitter samples it on the second edge after the opcode strobe).
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         output int lat, output int pulses,
                         output logic [7:0] data, output logic err);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    lat = 0;
    pulses = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge i_clock);
      #1;
      if (o_interface_done) begin
        pulses++;
        if (lat == 0) lat = e;
      end
    end
    data = o_interface_data;
    err  = o_op_error;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    total_cnt++;
    if ({o_interface_data, o_interface_done, o_busy, o_op_error, o_overrun} !== 12'h000)
      $display("FAIL reset_outputs: got data=%h done=%b busy=%b err=%b ovr=%b, need all 0",
               o_interface_data, o_interface_done, o_busy, o_op_error, o_overrun);
    else pass_cnt++;
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  task automatic test_add_latency();
    int lat, pulses;
    logic [7:0] d;
    logic e;
    run_cmd(8'h05, 8'h03, 8'h20, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'h08) $display("FAIL add_result: got %h, need 08", d); else pass_cnt++;
    total_cnt++;
    if (lat !== 1 || pulses !== 1)
      $display("FAIL add_done_timing: got lat=%0d pulses=%0d, need lat=1 pulses=1", lat, pulses);
    else pass_cnt++;
    total_cnt++;
    if (e !== 1'b0) $display("FAIL add_op_error: got %b, need 0", e); else pass_cnt++;
    send_tx();
  endtask

  task automatic test_sub_tx();
    int lat, pulses;
    logic [7:0] d;
    logic e;
    run_cmd(8'h03, 8'h05, 8'hE2, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'hFE) $display("FAIL sub_result: got %h, need fe", d); else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b1) $display("FAIL busy_wait_tx: got %b, need 1", o_busy); else pass_cnt++;
    send_tx();
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL busy_after_tx: got %b, need 0", o_busy); else pass_cnt++;
    // A stray tx_done in WAIT_A must not disturb the next command.
    send_tx();
    run_cmd(8'h0C, 8'h0A, 8'h24, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'h08 || pulses !== 1)
      $display("FAIL and_after_tx: got %h pulses=%0d, need 08 pulses=1", d, pulses);
    else pass_cnt++;
    send_tx();
  endtask

  task automatic test_shifts();
    logic [7:0] bv[4] = '{8'h02, 8'h02, 8'h09, 8'h09};
    logic [7:0] ov[4] = '{8'h03, 8'h02, 8'h03, 8'h02};
    int lat, pulses, r;
    bit me;
    logic [7:0] d;
    logic e;
    for (int i = 0; i < 4; i++) begin
      run_cmd(8'h80, bv[i], ov[i], lat, pulses, d, e);
      model(128, int'(bv[i]), int'(ov[i]), r, me);
      total_cnt++;
      if (d !== 8'(r)) $display("FAIL shift_%0d: got %h, need %h", i, d, 8'(r));
      else pass_cnt++;
      send_tx();
    end
  endtask

  task automatic test_invalid_op();
    int lat, pulses;
    logic [7:0] d;
    logic e;
    run_cmd(8'hF0, 8'h0F, 8'h3F, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'h00 || e !== 1'b1 || pulses !== 1)
      $display("FAIL invalid_op: got data=%h err=%b pulses=%0d, need 00 1 1", d, e, pulses);
    else pass_cnt++;
    send_tx();
    total_cnt++;
    if (o_op_error !== 1'b1) $display("FAIL op_error_hold: got %b, need 1", o_op_error);
    else pass_cnt++;
    run_cmd(8'h0F, 8'hF0, 8'h25, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'hFF || e !== 1'b0)
      $display("FAIL op_error_clear: got data=%h err=%b, need ff 0", d, e);
    else pass_cnt++;
    send_tx();
  endtask

  task automatic test_timeout();
    int lat, pulses;
    logic [7:0] d;
    logic e;
    send_byte(8'h55);
    repeat (20) @(posedge i_clock);
    run_cmd(8'h01, 8'h01, 8'h20, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'h02 || e !== 1'b0 || pulses !== 1)
      $display("FAIL timeout_abandon: got data=%h err=%b pulses=%0d, need 02 0 1", d, e, pulses);
    else pass_cnt++;
    send_tx();
  endtask

  task automatic test_overrun();
    int lat, pulses;
    logic [7:0] d;
    logic e;
    run_cmd(8'h11, 8'h22, 8'h26, lat, pulses, d, e);
    send_byte(8'h77);
    total_cnt++;
    if (o_overrun !== 1'b1) $display("FAIL overrun_pulse: got %b, need 1", o_overrun);
    else pass_cnt++;
    @(posedge i_clock);
    #1;
    total_cnt++;
    if (o_overrun !== 1'b0 || o_interface_data !== 8'h33)
      $display("FAIL overrun_clear: got ovr=%b data=%h, need 0 33", o_overrun, o_interface_data);
    else pass_cnt++;
    send_tx();
    run_cmd(8'h09, 8'h04, 8'h22, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'h05) $display("FAIL after_overrun: got %h, need 05", d); else pass_cnt++;
    send_tx();
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat, pulses;
    logic [7:0] d;
    logic e;
    send_byte(8'hAA);
    @(negedge i_clock);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    total_cnt++;
    if ({o_interface_data, o_interface_done, o_busy, o_op_error, o_overrun} !== 12'h000)
      $display("FAIL reset_mid_outputs: got data=%h done=%b busy=%b err=%b ovr=%b, need all 0",
               o_interface_data, o_interface_done, o_busy, o_op_error, o_overrun);
    else pass_cnt++;
    @(negedge i_clock);
    i_reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clock);
      #1;
      if (o_interface_done || o_busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_mid_quiet: got %0d active cycles, need 0", seen);
    else pass_cnt++;
    run_cmd(8'h07, 8'h06, 8'h20, lat, pulses, d, e);
    total_cnt++;
    if (d !== 8'h0D) $display("FAIL reset_mid_fresh: got %h, need 0d", d); else pass_cnt++;
    send_tx();
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    int lat, pulses, r;
    bit me;
    logic [7:0] a, b, op, d;
    logic e;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if ($urandom_range(0, 4) == 0) op = 8'($urandom);
      else op = {2'($urandom), ops[$urandom_range(0, 7)]};
      run_cmd(a, b, op, lat, pulses, d, e);
      model(int'(a), int'(b), int'(op), r, me);
      total_cnt++;
      if (d !== 8'(r) || e !== me || pulses !== 1 || lat !== 1)
        $display("FAIL random_%0d a=%h b=%h op=%h: got %h err=%b lat=%0d pulses=%0d, need %h err=%b lat=1 pulses=1",
                 i, a, b, op, d, e, lat, pulses, 8'(r), me);
      else pass_cnt++;
      send_tx();
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_tx();
    test_shifts();
    test_invalid_op();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
